// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, screen constants and trig table for tank_motion
//
// Contents:
//   state_t      update sequencer states
//   SCREEN_W/H   visible raster size in pixels
//   ANGLE_BITS   heading width (64 steps per turn)
//   FRAC_BITS    fraction bits of the 10.7 position format
//   TRIG_AMP     full-scale sin/cos magnitude
//   quarter_sin  17-entry quarter-wave table, round(127*sin(i*pi/32))
//   fold_sin     full-circle signed sin from a 6-bit heading
package tank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROTATE,
        LOOKUP,
        MOVE,
        CLAMP,
        OUTPUT
    } state_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int ANGLE_BITS = 6;
    localparam int FRAC_BITS  = 7;
    localparam int TRIG_AMP   = 127;

    function automatic logic [6:0] quarter_sin(input logic [4:0] i);
        logic [6:0] v;
        case (i)
            5'd0:    v = 7'd0;
            5'd1:    v = 7'd12;
            5'd2:    v = 7'd25;
            5'd3:    v = 7'd37;
            5'd4:    v = 7'd49;
            5'd5:    v = 7'd60;
            5'd6:    v = 7'd71;
            5'd7:    v = 7'd81;
            5'd8:    v = 7'd90;
            5'd9:    v = 7'd98;
            5'd10:   v = 7'd106;
            5'd11:   v = 7'd112;
            5'd12:   v = 7'd117;
            5'd13:   v = 7'd122;
            5'd14:   v = 7'd125;
            5'd15:   v = 7'd126;
            default: v = 7'(TRIG_AMP);
        endcase
        return v;
    endfunction

    // Quadrants 1 and 3 read the table mirrored; quadrants 2 and 3 negate.
    function automatic logic signed [7:0] fold_sin(input logic [ANGLE_BITS-1:0] a);
        logic [4:0] k;
        logic [7:0] m;
        k = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
        m = {1'b0, quarter_sin(k)};
        return a[5] ? -m : m;
    endfunction

endpackage

// File: rtl/sin_lut.sv
// rtl/sin_lut.sv - registered sin/cos lookup for a 6-bit heading
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; clears both outputs to 0
//   en     capture a new lookup of idx
//   idx    heading index, 0 = +X, counter-clockwise positive
//   sin_v  signed sin(idx)*127, valid the cycle after en
//   cos_v  signed cos(idx)*127, valid the cycle after en
module sin_lut
    import tank_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ANGLE_BITS-1:0] idx,
    output logic signed [7:0]     sin_v,
    output logic signed [7:0]     cos_v
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sin_v <= '0;
            cos_v <= '0;
        end else if (en) begin
            sin_v <= fold_sin(idx);
            // cos(a) = sin(a + quarter turn); the 6-bit add wraps mod 64.
            cos_v <= fold_sin(idx + 6'd16);
        end
    end

endmodule

// File: rtl/tank_motion.sv
// rtl/tank_motion.sv - per-frame tank kinematics feeding color_mapper
//
// Ports:
//   Clk        system clock
//   Reset      synchronous, active-high
//   frame_clk  VSync-derived frame tick, asynchronous to Clk
//   fwd/back   move forward / backward along the heading
//   rot_l      rotate CCW (heading +), rot_r rotate CW (heading -)
//   TankX/Y    registered integer position
//   sin_o      signed sin(heading)*127
//   cos_o      signed cos(heading)*127
//   busy       update in progress
module tank_motion
    import tank_pkg::*;
#(
    parameter logic [9:0]            X_INIT    = 10'd160,
    parameter logic [9:0]            Y_INIT    = 10'd240,
    parameter logic [ANGLE_BITS-1:0] HEAD_INIT = 6'd0,
    parameter logic [3:0]            SPEED     = 4'd2,
    parameter logic [ANGLE_BITS-1:0] ROT_STEP  = 6'd1,
    parameter logic [9:0]            SIZE      = 10'd8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              fwd,
    input  logic              back,
    input  logic              rot_l,
    input  logic              rot_r,
    output logic [9:0]        TankX,
    output logic [9:0]        TankY,
    output logic signed [7:0] sin_o,
    output logic signed [7:0] cos_o,
    output logic              busy
);

    localparam logic [9:0] X_HI = 10'(SCREEN_W - 1) - SIZE;
    localparam logic [9:0] Y_HI = 10'(SCREEN_H - 1) - SIZE;
    localparam int         PW   = 10 + FRAC_BITS;

    state_t                  state, state_next;
    logic [2:0]              fsync;
    logic                    tick;
    logic                    c_fwd, c_back, c_rl, c_rr;
    logic [ANGLE_BITS-1:0]   heading;
    logic [PW-1:0]           pos_x, pos_y;
    logic signed [7:0]       lut_sin, lut_cos;
    logic signed [PW:0]      spd, dx, dy, step_x, step_y, nx, ny;
    logic [PW-1:0]           move_x, move_y;

    sin_lut u_sin_lut (
        .clk   (Clk),
        .reset (Reset),
        .en    (state == LOOKUP),
        .idx   (heading),
        .sin_v (lut_sin),
        .cos_v (lut_cos)
    );

    // fsync[1] is the synchronized level, fsync[2] its previous value.
    assign tick = fsync[1] & ~fsync[2];
    // The accepting IDLE cycle counts as part of the update.
    assign busy = (state != IDLE) | tick;

    function automatic logic [PW-1:0] clamp_axis(input logic [PW-1:0] p,
                                                 input logic [9:0]    hi);
        if (p[PW-1:FRAC_BITS] < SIZE)
            return {SIZE, {FRAC_BITS{1'b0}}};
        if (p[PW-1:FRAC_BITS] > hi)
            return {hi, {FRAC_BITS{1'b0}}};
        return p;
    endfunction

    always_comb begin
        spd    = {{(PW + 1 - 4){1'b0}}, SPEED};
        dx     = (PW + 1)'(lut_cos) * spd;
        // Screen Y grows downward, so a positive sin moves the tank up.
        dy     = -((PW + 1)'(lut_sin) * spd);
        step_x = '0;
        step_y = '0;
        if (c_fwd && !c_back) begin
            step_x = dx;
            step_y = dy;
        end else if (c_back && !c_fwd) begin
            step_x = -dx;
            step_y = -dy;
        end
        nx     = $signed({1'b0, pos_x}) + step_x;
        ny     = $signed({1'b0, pos_y}) + step_y;
        move_x = nx[PW] ? '0 : nx[PW-1:0];
        move_y = ny[PW] ? '0 : ny[PW-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = ROTATE;
            ROTATE:  state_next = LOOKUP;
            LOOKUP:  state_next = MOVE;
            MOVE:    state_next = CLAMP;
            CLAMP:   state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            fsync   <= '0;
            c_fwd   <= 1'b0;
            c_back  <= 1'b0;
            c_rl    <= 1'b0;
            c_rr    <= 1'b0;
            heading <= HEAD_INIT;
            pos_x   <= {X_INIT, {FRAC_BITS{1'b0}}};
            pos_y   <= {Y_INIT, {FRAC_BITS{1'b0}}};
            TankX   <= X_INIT;
            TankY   <= Y_INIT;
            sin_o   <= fold_sin(HEAD_INIT);
            cos_o   <= fold_sin(HEAD_INIT + 6'd16);
        end else begin
            state <= state_next;
            fsync <= {fsync[1:0], frame_clk};
            case (state)
                IDLE: begin
                    if (tick) begin
                        c_fwd  <= fwd;
                        c_back <= back;
                        c_rl   <= rot_l;
                        c_rr   <= rot_r;
                    end
                end
                ROTATE: begin
                    if (c_rl && !c_rr)
                        heading <= heading + ROT_STEP;
                    else if (c_rr && !c_rl)
                        heading <= heading - ROT_STEP;
                end
                MOVE: begin
                    pos_x <= move_x;
                    pos_y <= move_y;
                end
                CLAMP: begin
                    pos_x <= clamp_axis(pos_x, X_HI);
                    pos_y <= clamp_axis(pos_y, Y_HI);
                end
                OUTPUT: begin
                    TankX <= pos_x[PW-1:FRAC_BITS];
                    TankY <= pos_y[PW-1:FRAC_BITS];
                    sin_o <= lut_sin;
                    cos_o <= lut_cos;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tank_motion.sv
// tb/tb_tank_motion.sv - directed self-checking bench for tank_motion
module tb_tank_motion;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_a, frame_b;
    logic       fwd, back, rot_l, rot_r, fwd_b;
    logic [9:0] tank_x, tank_y, tank_x_b, tank_y_b;
    logic [7:0] sin_a, cos_a, sin_b, cos_b;
    logic       busy_a, busy_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    tank_motion u_dut (
        .Clk       (clk),
        .Reset     (reset),
        .frame_clk (frame_a),
        .fwd       (fwd),
        .back      (back),
        .rot_l     (rot_l),
        .rot_r     (rot_r),
        .TankX     (tank_x),
        .TankY     (tank_y),
        .sin_o     (sin_a),
        .cos_o     (cos_a),
        .busy      (busy_a)
    );

    tank_motion #(.X_INIT(10'd630)) u_dut_b (
        .Clk       (clk),
        .Reset     (reset),
        .frame_clk (frame_b),
        .fwd       (fwd_b),
        .back      (1'b0),
        .rot_l     (1'b0),
        .rot_r     (1'b0),
        .TankX     (tank_x_b),
        .TankY     (tank_y_b),
        .sin_o     (sin_b),
        .cos_o     (cos_b),
        .busy      (busy_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick on instance a (sel=0) or b (sel=1), then wait for the update to finish.
    task automatic frames(input bit sel, input int n);
        for (int f = 0; f < n; f++) begin
            if (sel) frame_b = 1'b1; else frame_a = 1'b1;
            repeat (3) @(negedge clk);
            frame_a = 1'b0;
            frame_b = 1'b0;
            for (int t = 0; t < 20 && (sel ? busy_b : busy_a); t++)
                @(negedge clk);
            check("busy_done", int'(sel ? busy_b : busy_a), 0);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        reset   = 1'b1;
        frame_a = 1'b0;
        frame_b = 1'b0;
        fwd     = 1'b0;
        back    = 1'b0;
        rot_l   = 1'b0;
        rot_r   = 1'b0;
        fwd_b   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tank_x", int'(tank_x), 160);
        check("rst_tank_y", int'(tank_y), 240);
        check("rst_sin", int'($signed(sin_a)), 0);
        check("rst_cos", int'($signed(cos_a)), 127);
        check("rst_busy", int'(busy_a), 0);
        check("rst_tank_x_b", int'(tank_x_b), 630);

        // Right-edge clamp on the X_INIT=630 instance.
        fwd_b = 1'b1;
        frames(1'b1, 1);
        check("clamp_f1_x", int'(tank_x_b), 631);
        for (int i = 0; i < 4; i++) begin
            frames(1'b1, 1);
            check("clamp_hold_x", int'(tank_x_b), 631);
        end
        check("clamp_y", int'(tank_y_b), 240);
        fwd_b = 1'b0;

        // Forward along +X: 254/128 pixel per frame.
        fwd = 1'b1;
        frames(1'b0, 1);
        check("fwd1_x", int'(tank_x), 161);
        check("fwd1_y", int'(tank_y), 240);
        frames(1'b0, 1);
        check("fwd2_x", int'(tank_x), 163);
        check("fwd2_y", int'(tank_y), 240);
        fwd = 1'b0;

        // Quarter turn CCW, then forward moves up the screen.
        rot_l = 1'b1;
        frames(1'b0, 16);
        rot_l = 1'b0;
        check("h16_sin", int'($signed(sin_a)), 127);
        check("h16_cos", int'($signed(cos_a)), 0);
        fwd = 1'b1;
        frames(1'b0, 1);
        fwd = 1'b0;
        check("up_y", int'(tank_y), 238);
        check("up_x", int'(tank_x), 163);

        // Heading 16 - 17 wraps to 63.
        rot_r = 1'b1;
        frames(1'b0, 17);
        rot_r = 1'b0;
        check("h63_sin", int'($signed(sin_a)), -12);
        check("h63_cos", int'($signed(cos_a)), 126);
        rot_l = 1'b1;
        frames(1'b0, 1);
        rot_l = 1'b0;
        check("wrap_up_cos", int'($signed(cos_a)), 127);
        check("wrap_up_sin", int'($signed(sin_a)), 0);
        rot_r = 1'b1;
        frames(1'b0, 1);
        check("wrap_dn_sin", int'($signed(sin_a)), -12);
        check("wrap_dn_cos", int'($signed(cos_a)), 126);

        // All controls high cancel out.
        fwd   = 1'b1;
        back  = 1'b1;
        rot_l = 1'b1;
        frames(1'b0, 1);
        fwd   = 1'b0;
        back  = 1'b0;
        rot_l = 1'b0;
        rot_r = 1'b0;
        check("all_x", int'(tank_x), 163);
        check("all_y", int'(tank_y), 238);
        check("all_sin", int'($signed(sin_a)), -12);
        check("all_cos", int'($signed(cos_a)), 126);

        // Reset in MOVE, three cycles after the tick cycle.
        frame_a = 1'b1;
        for (int t = 0; t < 10 && !busy_a; t++)
            @(negedge clk);
        check("tick_seen", int'(busy_a), 1);
        frame_a = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_x", int'(tank_x), 160);
        check("mid_rst_y", int'(tank_y), 240);
        check("mid_rst_sin", int'($signed(sin_a)), 0);
        check("mid_rst_cos", int'($signed(cos_a)), 127);
        repeat (2) @(negedge clk);

        cnt = 0;
        frame_a = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 2) frame_a = 1'b0;
            if (busy_a) cnt++;
        end
        check("busy_cycles", cnt, 6);
        check("post_x", int'(tank_x), 160);
        check("post_y", int'(tank_y), 240);
        check("post_cos", int'($signed(cos_a)), 127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
